raster_counter: RTL and testbench
=================================

// Module: raster_counter
// PURPOSE
//  Two-axis (column/row) scan counter generalising the single-axis rollover counter to full image frames.
//  Generates pixel x/y coordinates, line-end and frame-end flags, and a one-cycle frame_done pulse.
//  Sequences buffer read/write addressing in the image-filter datapath; one instance per frame walker.
// PARAMETERS
//  X_BITS   10   width of column counter and x_max
//  Y_BITS   9    width of row counter and y_max
// PORTS
//  clk           in   1       system clock, rising edge
//  rst           in   1       asynchronous reset, active-high
//  clear         in   1       synchronous abort: to IDLE, counts to 0
//  start         in   1       begin a frame (honoured in IDLE or DONE only)
//  count_enable  in   1       advance one pixel this cycle (RUN only)
//  x_max         in   X_BITS  last column index, sampled on accepted start
//  y_max         in   Y_BITS  last row index, sampled on accepted start
//  x_count       out  X_BITS  current column
//  y_count       out  Y_BITS  current row
//  line_end      out  1       x_count == latched x_max (RUN only)
//  frame_end     out  1       line_end && y_count == latched y_max
//  frame_done    out  1       one-cycle pulse after last pixel consumed
//  busy          out  1       state == RUN
// BEHAVIOUR
//  - Reset (async): state IDLE, x/y counts 0, latched limits 0, all flags 0.
//  - All outputs registered; line_end/frame_end computed from next-state counts so they align with x/y.
//  - FSM: IDLE -start-> RUN; RUN -enable on last pixel-> DONE; DONE -start-> RUN; any -clear-> IDLE.
//  - Priority per cycle: clear > start > count_enable.
//  - Accepted start: latch x_max/y_max, x=y=0, busy=1 next cycle; flags evaluated for (0,0) immediately.
//  - start ignored while RUN; x_max/y_max changes mid-frame have no effect.
//  - RUN, enable=1: x<xmax -> x+1; x==xmax,y<ymax -> x=0,y+1; last pixel -> DONE, frame_done=1 one cycle.
//  - RUN, enable=0: counts and flags hold.
//  - DONE: counts hold at (xmax,ymax), line_end/frame_end deasserted, enable ignored.
//  - x_max=0: every enable advances a row; line_end constant 1 in RUN. x_max=y_max=0: first enable ends frame.
//  - No arithmetic overflow: counts never exceed latched limits; increments are X_BITS/Y_BITS modular-free.
//  - clear during RUN: no frame_done, next cycle IDLE with zero counts.
//  - rst mid-frame: immediate return to reset values, no pulse.
// CONFIGURATION
//  - Macro RASTER_CNT_CONT_EN defined: extra input port `continuous` (1 bit) present.
//    continuous=1: last pixel wraps to (0,0) staying in RUN, frame_done still pulses, limits re-latched from
//    current x_max/y_max at the wrap. continuous=0: single-shot as above.
//  - Macro undefined: port absent, always single-shot.
// STRUCTURE
//  - Package raster_cnt_pkg: typedef enum logic [1:0] {RC_IDLE, RC_RUN, RC_DONE} rc_state_t.
//  - Sub-module raster_axis_counter #(W): count, max latch, inc, wrap_to_zero, at_max output;
//    instantiated twice (x chained: y inc = x at_max && enable).
//  - Top holds FSM, priority logic, flag and pulse registers.
// TESTING
//  - rst=1 mid-count, release -> all outputs 0, state IDLE, busy=0.
//  - x_max=3,y_max=2, start, enable held 12 cycles -> x 0..3 repeating, y 0..2, line_end on x=3,
//    frame_end on (3,2), frame_done pulses exactly once in cycle 12, busy drops same edge.
//  - Same frame, enable toggled every other cycle -> counts hold on idle cycles, done after 24 cycles.
//  - Change x_max to 7 at (1,1) mid-frame -> row still wraps at x=3.
//  - clear and start same cycle at (2,1) -> IDLE, counts 0, no frame_done.
//  - x_max=0,y_max=0: start then one enable -> frame_done next cycle; with RASTER_CNT_CONT_EN and
//    continuous=1, x_max=1,y_max=1: 8 enables -> two frame_done pulses, busy stays 1.

Source files
------------

// File: rtl/raster_cnt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : raster_cnt_pkg
// Description : Shared types for the raster scan counter (frame walker FSM
//               state encoding).
// Revision    : 1.0 - initial release
// ============================================================================
package raster_cnt_pkg;

    // Frame walker states: waiting for start, scanning, frame finished
    typedef enum logic [1:0] {
        RC_IDLE = 2'd0,
        RC_RUN  = 2'd1,
        RC_DONE = 2'd2
    } rc_state_t;

endpackage
`default_nettype wire

// File: rtl/raster_axis_counter.sv
`default_nettype none
// ============================================================================
// Module      : raster_axis_counter
// Description : One axis of the raster scan. Holds the current index and the
//               limit latched at frame start; increments wrap to zero once
//               the latched limit is reached. Exposes the at-limit flag for
//               both the current and the next-cycle value so the parent can
//               register flags aligned with the count.
// Revision    : 1.0 - initial release
// ============================================================================
module raster_axis_counter
    import raster_cnt_pkg::*;
#(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] max_in,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         at_max,
    output logic         at_max_nxt
);

    logic [W-1:0] r_count;
    logic [W-1:0] r_limit;
    logic [W-1:0] w_count_nxt;
    logic [W-1:0] w_limit_nxt;
    logic         w_wrap_to_zero;

    // The count never passes the latched limit, so no modular overflow occurs
    assign w_wrap_to_zero = (r_count == r_limit);

    // Next count/limit: clear beats load beats increment
    always_comb begin
        w_count_nxt = r_count;
        w_limit_nxt = r_limit;
        if (clear) begin
            w_count_nxt = '0;
        end else if (load) begin
            w_count_nxt = '0;
            w_limit_nxt = max_in;
        end else if (inc) begin
            w_count_nxt = w_wrap_to_zero ? '0 : r_count + W'(1);
        end
    end

    // Count and limit registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_limit <= '0;
        end else begin
            r_count <= w_count_nxt;
            r_limit <= w_limit_nxt;
        end
    end

    assign count      = r_count;
    assign at_max     = w_wrap_to_zero;
    assign at_max_nxt = (w_count_nxt == w_limit_nxt);

endmodule
`default_nettype wire

// File: rtl/raster_counter.sv
`default_nettype none
// ============================================================================
// Module      : raster_counter
// Description : Two-axis column/row scan counter. Walks x across each row and
//               y down the frame, flags line end / frame end, and pulses
//               frame_done for one cycle after the last pixel is consumed.
//               Optional macro RASTER_CNT_CONT_EN adds a `continuous` input
//               that wraps the frame back to (0,0) instead of stopping.
// Revision    : 1.0 - initial release
// ============================================================================
module raster_counter
    import raster_cnt_pkg::*;
#(
    parameter int X_BITS = 10,
    parameter int Y_BITS = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              start,
    input  logic              count_enable,
`ifdef RASTER_CNT_CONT_EN
    input  logic              continuous,
`endif
    input  logic [X_BITS-1:0] x_max,
    input  logic [Y_BITS-1:0] y_max,
    output logic [X_BITS-1:0] x_count,
    output logic [Y_BITS-1:0] y_count,
    output logic              line_end,
    output logic              frame_end,
    output logic              frame_done,
    output logic              busy
);

    rc_state_t r_state;
    rc_state_t w_state_nxt;
    logic      w_cont;
    logic      w_cnt_clear;
    logic      w_load;
    logic      w_x_inc;
    logic      w_y_inc;
    logic      w_done_nxt;
    logic      w_x_at_max;
    logic      w_y_at_max;
    logic      w_x_at_max_nxt;
    logic      w_y_at_max_nxt;
    logic      w_line_end_nxt;
    logic      w_frame_end_nxt;
    logic      r_line_end;
    logic      r_frame_end;
    logic      r_frame_done;
    logic      r_busy;

`ifdef RASTER_CNT_CONT_EN
    assign w_cont = continuous;
`else
    assign w_cont = 1'b0;
`endif

    raster_axis_counter #(.W(X_BITS)) u_x_axis (
        .clk        (clk),
        .rst        (rst),
        .clear      (w_cnt_clear),
        .load       (w_load),
        .max_in     (x_max),
        .inc        (w_x_inc),
        .count      (x_count),
        .at_max     (w_x_at_max),
        .at_max_nxt (w_x_at_max_nxt)
    );

    raster_axis_counter #(.W(Y_BITS)) u_y_axis (
        .clk        (clk),
        .rst        (rst),
        .clear      (w_cnt_clear),
        .load       (w_load),
        .max_in     (y_max),
        .inc        (w_y_inc),
        .count      (y_count),
        .at_max     (w_y_at_max),
        .at_max_nxt (w_y_at_max_nxt)
    );

    // Sequencing with priority clear > start > count_enable; a continuous
    // wrap reuses the load path so limits are re-sampled at the frame edge
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clear = 1'b0;
        w_load      = 1'b0;
        w_x_inc     = 1'b0;
        w_y_inc     = 1'b0;
        w_done_nxt  = 1'b0;
        if (clear) begin
            w_state_nxt = RC_IDLE;
            w_cnt_clear = 1'b1;
        end else if (start && (r_state != RC_RUN)) begin
            w_state_nxt = RC_RUN;
            w_load      = 1'b1;
        end else if ((r_state == RC_RUN) && count_enable) begin
            if (w_x_at_max && w_y_at_max) begin
                w_done_nxt = 1'b1;
                if (w_cont) begin
                    w_load = 1'b1;
                end else begin
                    w_state_nxt = RC_DONE;
                end
            end else begin
                w_x_inc = 1'b1;
                w_y_inc = w_x_at_max;
            end
        end
    end

    // Flags are derived from next-cycle counts so they line up with x/y
    assign w_line_end_nxt  = (w_state_nxt == RC_RUN) && w_x_at_max_nxt;
    assign w_frame_end_nxt = w_line_end_nxt && w_y_at_max_nxt;

    // State, flag and pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= RC_IDLE;
            r_line_end   <= 1'b0;
            r_frame_end  <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_line_end   <= w_line_end_nxt;
            r_frame_end  <= w_frame_end_nxt;
            r_frame_done <= w_done_nxt;
            r_busy       <= (w_state_nxt == RC_RUN);
        end
    end

    assign line_end   = r_line_end;
    assign frame_end  = r_frame_end;
    assign frame_done = r_frame_done;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_raster_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_raster_counter
// Description : Self-checking bench for raster_counter: vector table for a
//               full 4x3 frame and degenerate limits, plus hand sequences for
//               gated enables, mid-frame limit change, clear/start collision,
//               async reset and (when RASTER_CNT_CONT_EN) continuous mode.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_raster_counter;

    logic       clk;
    logic       rst;
    logic       clear;
    logic       start;
    logic       count_enable;
    logic [9:0] x_max;
    logic [8:0] y_max;
    logic [9:0] x_count;
    logic [8:0] y_count;
    logic       line_end;
    logic       frame_end;
    logic       frame_done;
    logic       busy;
`ifdef RASTER_CNT_CONT_EN
    logic       continuous;
`endif

    int checks   = 0;
    int failures = 0;

    raster_counter #(.X_BITS(10), .Y_BITS(9)) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .start        (start),
        .count_enable (count_enable),
`ifdef RASTER_CNT_CONT_EN
        .continuous   (continuous),
`endif
        .x_max        (x_max),
        .y_max        (y_max),
        .x_count      (x_count),
        .y_count      (y_count),
        .line_end     (line_end),
        .frame_end    (frame_end),
        .frame_done   (frame_done),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       st;
        logic       en;
        logic       clr;
        logic [9:0] xm;
        logic [8:0] ym;
        logic [9:0] x;
        logic [8:0] y;
        logic       le;
        logic       fe;
        logic       fd;
        logic       bz;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] pk(input logic [9:0] x, input logic [8:0] y,
                                       input logic le, input logic fe,
                                       input logic fd, input logic bz);
        return {9'd0, x, y, le, fe, fd, bz};
    endfunction

    function automatic logic [31:0] obs();
        return pk(x_count, y_count, line_end, frame_end, frame_done, busy);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h (x,y,le,fe,fd,busy packed)", name, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic en, input logic clr,
                       input logic [9:0] xm, input logic [8:0] ym,
                       input logic [9:0] x, input logic [8:0] y,
                       input logic le, input logic fe, input logic fd, input logic bz);
        vec_t v;
        v = '{st, en, clr, xm, ym, x, y, le, fe, fd, bz};
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0;
        count_enable = 1'b0;
        clear = 1'b0;
    endtask

    int ex;
    int ey;
    int pulses;
    logic exp_fd;
    logic exp_bz;
    logic exp_le;

    initial begin
        // 4x3 frame with enable held, then restart from DONE with 1x1 and 1x2
        add(1,0,0, 3,2, 0,0, 0,0,0,1);
        add(0,1,0, 3,2, 1,0, 0,0,0,1);
        add(0,1,0, 3,2, 2,0, 0,0,0,1);
        add(0,1,0, 3,2, 3,0, 1,0,0,1);
        add(0,1,0, 3,2, 0,1, 0,0,0,1);
        add(0,1,0, 3,2, 1,1, 0,0,0,1);
        add(0,1,0, 3,2, 2,1, 0,0,0,1);
        add(0,1,0, 3,2, 3,1, 1,0,0,1);
        add(0,1,0, 3,2, 0,2, 0,0,0,1);
        add(0,1,0, 3,2, 1,2, 0,0,0,1);
        add(0,1,0, 3,2, 2,2, 0,0,0,1);
        add(0,1,0, 3,2, 3,2, 1,1,0,1);
        add(0,1,0, 3,2, 3,2, 0,0,1,0);
        add(0,0,0, 3,2, 3,2, 0,0,0,0);
        add(1,0,0, 0,0, 0,0, 1,1,0,1);
        add(0,1,0, 0,0, 0,0, 0,0,1,0);
        add(1,0,0, 0,1, 0,0, 1,0,0,1);
        add(0,1,0, 0,1, 0,1, 1,1,0,1);
        add(0,1,0, 0,1, 0,1, 0,0,1,0);
        add(0,1,0, 0,1, 0,1, 0,0,0,0);

        rst = 1'b1;
        idle_inputs();
        x_max = 10'd0;
        y_max = 9'd0;
`ifdef RASTER_CNT_CONT_EN
        continuous = 1'b0;
`endif
        step();
        step();
        check("reset_held", obs(), pk(0,0,0,0,0,0));
        rst = 1'b0;
        step();
        check("reset_release", obs(), pk(0,0,0,0,0,0));

        // Vector table
        for (int i = 0; i < vecs.size(); i++) begin
            start = vecs[i].st;
            count_enable = vecs[i].en;
            clear = vecs[i].clr;
            x_max = vecs[i].xm;
            y_max = vecs[i].ym;
            step();
            check($sformatf("vec%0d", i), obs(),
                  pk(vecs[i].x, vecs[i].y, vecs[i].le, vecs[i].fe, vecs[i].fd, vecs[i].bz));
        end
        idle_inputs();

        // Enable on alternate cycles; x_max moved to 7 at (1,1); stray start mid-run
        x_max = 10'd3;
        y_max = 9'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        check("toggle_start", obs(), pk(0,0,0,0,0,1));
        ex = 0;
        ey = 0;
        exp_bz = 1'b1;
        for (int i = 0; i < 24; i++) begin
            count_enable = i[0];
            if (ex == 1 && ey == 1) x_max = 10'd7;
            start = (ex == 2 && ey == 1 && !count_enable) ? 1'b1 : 1'b0;
            step();
            exp_fd = 1'b0;
            if (count_enable && exp_bz) begin
                if (ex == 3 && ey == 2) begin
                    exp_fd = 1'b1;
                    exp_bz = 1'b0;
                end else if (ex == 3) begin
                    ex = 0;
                    ey++;
                end else begin
                    ex++;
                end
            end
            exp_le = exp_bz && (ex == 3);
            check($sformatf("toggle%0d", i), obs(),
                  pk(10'(ex), 9'(ey), exp_le, exp_le && (ey == 2), exp_fd, exp_bz));
        end
        idle_inputs();
        step();
        check("toggle_after", obs(), pk(3,2,0,0,0,0));

        // Clear and start together at (2,1)
        x_max = 10'd3;
        y_max = 9'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        count_enable = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("pre_clear", obs(), pk(2,1,0,0,0,1));
        clear = 1'b1;
        start = 1'b1;
        step();
        check("clear_start", obs(), pk(0,0,0,0,0,0));
        clear = 1'b0;
        start = 1'b0;
        step();
        check("clear_idle_enable_ignored", obs(), pk(0,0,0,0,0,0));
        idle_inputs();

        // Async reset mid-frame
        start = 1'b1;
        step();
        start = 1'b0;
        count_enable = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("pre_reset", obs(), pk(1,1,0,0,0,1));
        rst = 1'b1;
        #1;
        check("async_reset", obs(), pk(0,0,0,0,0,0));
        step();
        rst = 1'b0;
        step();
        check("post_reset", obs(), pk(0,0,0,0,0,0));
        idle_inputs();
        start = 1'b1;
        step();
        start = 1'b0;
        check("post_reset_start", obs(), pk(0,0,0,0,0,1));
        clear = 1'b1;
        step();
        clear = 1'b0;

`ifdef RASTER_CNT_CONT_EN
        // Continuous 2x2 frames: two pulses, busy never drops
        continuous = 1'b1;
        x_max = 10'd1;
        y_max = 9'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        count_enable = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (frame_done) pulses++;
            check($sformatf("cont_busy%0d", i), {31'd0, busy}, 32'd1);
        end
        check("cont_pulses", pulses, 2);
        count_enable = 1'b0;
        step();
        check("cont_end", obs(), pk(0,0,0,0,0,1));
        continuous = 1'b0;
        clear = 1'b1;
        step();
        idle_inputs();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
